uarttx_arbiter: RTL and testbench
=================================

UARTTX_ARBITER -- requirements
Module: uarttx_arbiter

Interface
REQ-001 The block SHALL have parameter NumRequesters, default 4, meaning the number of byte requesters; legal range is 2..16.
REQ-002 The block SHALL have parameter CountWidth, default 16, meaning the width of the transmitted-byte counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, NumRequesters bits: per-requester request, held high until that requester's ack.
REQ-006 The block SHALL have port req_data, input, NumRequesters*8 bits: byte i is at bits [8*i+7:8*i]; it is held stable while req[i] is high.
REQ-007 The block SHALL have port ack, output, NumRequesters bits: a one-cycle pulse on bit i when requester i's byte has been fully transmitted.
REQ-008 The block SHALL have port tx_go, output, 1 bit: drives the transmitter's go input.
REQ-009 The block SHALL have port tx_data, output, 8 bits: drives the transmitter's data input.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: the transmitter's busy output.
REQ-011 The block SHALL have port active, output, 1 bit: high whenever the state is not Idle.
REQ-012 The block SHALL have port grant_id, output, $clog2(NumRequesters) bits: index of the current or most recent grant.
REQ-013 The block SHALL have port tx_count, output, CountWidth bits: number of completed transfers, wrapping modulo 2^CountWidth.

Function
REQ-014 The state machine SHALL have exactly the states Idle, Send and Release.
REQ-015 In Idle with any req bit high, the block SHALL, at the next edge, select the first requester with req high at or after pointer rr_ptr, scanning upward with wrap.
REQ-016 On that grant edge, the block SHALL register the requester index into grant_id, latch its req_data byte into tx_data, clear the busy_seen flag and enter Send.
REQ-017 In Send, tx_go SHALL be 1; tx_data SHALL hold the latched byte and SHALL NOT follow later changes on req_data.
REQ-018 In Send, busy_seen SHALL be set at any edge where tx_busy is 1.
REQ-019 In Send, the block SHALL move to Release at the first edge where busy_seen is already 1 and tx_busy is 0.
REQ-020 A tx_busy that is 0 before busy_seen is set SHALL NOT end Send; this covers the transmitter's Idle-to-busy transition.
REQ-021 Release SHALL last exactly one cycle, with tx_go at 0.
REQ-022 During Release, ack[grant_id] SHALL be 1 and all other ack bits SHALL be 0; ack is decoded from registered state.
REQ-023 On the edge leaving Release, the block SHALL set rr_ptr to (grant_id+1) mod NumRequesters, increment tx_count with wrap to 0 past all-ones, and enter Idle.
REQ-024 A requester that sees ack SHALL lower req or present a new byte on the same edge; Idle samples the updated req one cycle after Release.
REQ-025 Back-to-back bytes: the minimum gap between transfers SHALL be Release plus Idle, i.e. 2 cycles with tx_go low before the next Send.
REQ-026 Deassertion of req[grant_id] during Send SHALL be ignored: the transfer completes and ack still pulses.
REQ-027 Changes on req during Send or Release SHALL NOT affect the current grant; they are considered only in Idle.
REQ-028 Outside Release, ack SHALL be all zeros; tx_go SHALL be 1 only in Send.
REQ-029 Simultaneous requests SHALL be served one byte per grant in round-robin order; no requester waits more than NumRequesters-1 other transfers.
REQ-030 If NumRequesters is not a power of two, rr_ptr SHALL still wrap to 0 after NumRequesters-1.

Reset
REQ-031 At an edge with rst=1, the block SHALL set state to Idle, tx_go to 0, ack to 0, tx_data to 0x00, grant_id to 0, rr_ptr to 0, tx_count to 0 and busy_seen to 0.
REQ-032 Reset SHALL take priority over all other events, including mid-Send, where tx_go drops at the reset edge.
REQ-033 No ack SHALL be issued for an aborted transfer.
REQ-034 The transmitter SHALL share the same reset so that both return to their idle states together.

Verification
REQ-035 The bench SHALL cover: single request, req=0b0100 with byte 0x5A -> grant_id=2, tx_data=0x5A, tx_go high until busy falls, then ack=0b0100 for 1 cycle and tx_count=1.
REQ-036 The bench SHALL cover: all four requesting from reset with bytes 0x10,0x11,0x12,0x13 -> serial output order 0x10,0x11,0x12,0x13 and ack pulses in order on bits 0,1,2,3.
REQ-037 The bench SHALL cover: requesters 1 and 3 continuously requesting after serving 3 -> grants alternate 1,3,1,3; requesters 0 and 2 are never acked.
REQ-038 The bench SHALL cover: req[0] dropped and req_data changed to 0xFF during Send of 0x33 -> the line carries 0x33 and ack[0] still pulses.
REQ-039 The bench SHALL cover: rst asserted mid data bits -> the next cycle shows tx_go=0, active=0, ack=0, tx_count=0, and the transmitter line idles high.
REQ-040 The bench SHALL cover: CountWidth=4 with 17 transfers -> tx_count reads 15 after the 15th, 0 after the 16th and 1 after the 17th.

Source files
------------

// File: rtl/uarttx_arbiter.sv
// Round-robin arbiter that hands one byte per grant from NumRequesters sources to a
// single UART transmitter through its go/busy handshake, and acks each source when done.
module uarttx_arbiter #(
    parameter int NumRequesters = 4,
    parameter int CountWidth    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NumRequesters-1:0]           req,
    input  logic [NumRequesters*8-1:0]         req_data,
    output logic [NumRequesters-1:0]           ack,
    output logic                               tx_go,
    output logic [7:0]                         tx_data,
    input  logic                               tx_busy,
    output logic                               active,
    output logic [$clog2(NumRequesters)-1:0]   grant_id,
    output logic [CountWidth-1:0]              tx_count,
    output logic [1:0]                         state_dbg
);

    localparam int IdW  = $clog2(NumRequesters);
    localparam int SumW = IdW + 1;

    // Handshakes: a requester holds req[i] and its byte stable until a single-cycle
    // ack[i]; toward the transmitter, tx_go is held for the whole Send phase and the
    // byte counts as done only once busy has been seen high and has fallen again.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_seen_q, busy_seen_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [IdW-1:0]        ptr_q, ptr_d;
    logic [7:0]            data_q, data_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [IdW-1:0]        pick;
    logic [SumW-1:0]       cand;

    // Scanning downward lets the lowest offset from ptr_q win without a found flag.
    always_comb begin
        pick = ptr_q;
        cand = '0;
        for (int k = NumRequesters - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + SumW'(k);
            if (cand >= SumW'(NumRequesters)) begin
                cand = cand - SumW'(NumRequesters);
            end
            if (req[cand[IdW-1:0]]) begin
                pick = cand[IdW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_seen_d = busy_seen_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_SEND;
                    grant_d     = pick;
                    data_d      = req_data[8*pick +: 8];
                    busy_seen_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end
                if (busy_seen_q && !tx_busy) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                ptr_d   = (grant_q == IdW'(NumRequesters - 1)) ? '0 : grant_q + 1'b1;
                count_d = count_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_seen_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
            data_q      <= 8'h00;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_seen_q <= busy_seen_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == ST_RELEASE) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign tx_go     = (state_q == ST_SEND);
    assign active    = (state_q != ST_IDLE);
    assign tx_data   = data_q;
    assign grant_id  = grant_q;
    assign tx_count  = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uarttx_arbiter.sv
// Bench for uarttx_arbiter: a behavioural UART transmitter, queue-driven requesters,
// a transaction-level arbitration model and a serial-line scoreboard.
module tb_uarttx_arbiter;

    localparam int NR      = 4;
    localparam int CW      = 4;
    localparam int IW      = $clog2(NR);
    localparam int BIT_CYC = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*8-1:0]  req_data = '0;
    logic [NR-1:0]    ack;
    logic             tx_go;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             active;
    logic [IW-1:0]    grant_id;
    logic [CW-1:0]    tx_count;
    logic [1:0]       state_dbg;
    logic             tx_line;

    always #5 clk = ~clk;

    uarttx_arbiter #(.NumRequesters(NR), .CountWidth(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_go(tx_go), .tx_data(tx_data), .tx_busy(tx_busy), .active(active),
        .grant_id(grant_id), .tx_count(tx_count), .state_dbg(state_dbg)
    );

    // Transmitter: random start latency, 8N1 frame, re-arms only after go falls.
    int         tx_lat_max = 0;
    int         xs = 0;
    int         x_wait = 0;
    int         x_cyc = 0;
    int         x_bit = 0;
    logic [9:0] x_sh = '1;
    logic       x_armed = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            xs      <= 0;
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            x_armed <= 1'b1;
        end else begin
            case (xs)
                0: begin
                    if (tx_go && x_armed) begin
                        x_armed <= 1'b0;
                        x_wait  <= $urandom_range(tx_lat_max, 0);
                        x_sh    <= {1'b1, tx_data, 1'b0};
                        xs      <= 1;
                    end else if (!tx_go) begin
                        x_armed <= 1'b1;
                    end
                end
                1: begin
                    if (x_wait == 0) begin
                        xs      <= 2;
                        tx_busy <= 1'b1;
                        tx_line <= x_sh[0];
                        x_bit   <= 0;
                        x_cyc   <= 0;
                    end else begin
                        x_wait <= x_wait - 1;
                    end
                end
                default: begin
                    if (x_cyc == BIT_CYC - 1) begin
                        x_cyc <= 0;
                        if (x_bit == 9) begin
                            xs      <= 0;
                            tx_busy <= 1'b0;
                            tx_line <= 1'b1;
                        end else begin
                            x_bit   <= x_bit + 1;
                            tx_line <= x_sh[x_bit+1];
                        end
                    end else begin
                        x_cyc <= x_cyc + 1;
                    end
                end
            endcase
        end
    end

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q[NR][$];
    int         ack_log[$];
    logic [7:0] rx_log[$];
    bit         rand_raise = 1'b0;

    // Model: 0 = no transfer, 1 = byte on offer, 2 = ack cycle.
    int         m_phase = 0;
    int         m_gid = 0;
    int         m_ptr = 0;
    int         m_count = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_seen = 1'b0;

    bit         d_on = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    function automatic int ack_at(input int i);
        return (i < ack_log.size()) ? ack_log[i] : -1;
    endfunction

    function automatic int rx_at(input int i);
        return (i < rx_log.size()) ? int'(rx_log[i]) : -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_next();
        if (rst) begin
            m_phase = 0; m_gid = 0; m_ptr = 0; m_count = 0; m_byte = 8'h00; m_seen = 1'b0;
            exp_q.delete();
            d_on = 1'b0;
        end else begin
            case (m_phase)
                0: if (req != '0) begin
                    m_gid   = rr_pick(req, m_ptr);
                    m_byte  = req_data[8*m_gid +: 8];
                    m_seen  = 1'b0;
                    m_phase = 1;
                    exp_q.push_back(m_byte);
                end
                1: begin
                    if (m_seen && !tx_busy) m_phase = 2;
                    if (tx_busy) m_seen = 1'b1;
                end
                default: begin
                    m_phase = 0;
                    m_count = (m_count + 1) % (1 << CW);
                    m_ptr   = (m_gid + 1) % NR;
                end
            endcase
        end
    endtask

    task automatic cycle_checks();
        check("tx_go", tx_go, m_phase == 1);
        check("ack", ack, (m_phase == 2) ? (32'd1 << m_gid) : 32'd0);
        check("active", active, m_phase != 0);
        check("grant_id", grant_id, m_gid);
        check("tx_data", tx_data, m_byte);
        check("tx_count", tx_count, m_count);
        for (int i = 0; i < NR; i++) if (ack[i]) ack_log.push_back(i);
    endtask

    task automatic decode_line();
        if (!d_on) begin
            if (tx_line == 1'b0) begin
                d_on  = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt % BIT_CYC == 2 && d_cnt / BIT_CYC >= 1 && d_cnt / BIT_CYC <= 8)
                d_byte[d_cnt / BIT_CYC - 1] = tx_line;
            if (d_cnt == 9 * BIT_CYC + 2) begin
                check("stop_bit", tx_line, 1);
                check("rx_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rx_byte", d_byte, exp_q.pop_front());
                rx_log.push_back(d_byte);
                d_on = 1'b0;
            end
        end
    endtask

    task automatic drive_requesters();
        for (int i = 0; i < NR; i++) begin
            if (ack[i]) begin
                if (src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0];
                end else begin
                    req[i] = 1'b0;
                end
            end else if (!req[i] && src_q[i].size() > 0 &&
                         (!rand_raise || $urandom_range(3, 0) == 0)) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = src_q[i][0];
            end
        end
    endtask

    task automatic step();
        model_next();
        @(negedge clk);
        cycle_checks();
        decode_line();
        drive_requesters();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_phase != 0 || req != '0 || pending() || d_on) && n < budget) begin
            step();
            n++;
        end
        check("wait_idle_timeout", n < budget, 1);
        step();
        step();
    endtask

    initial begin
        int n;
        apply_reset();
        check("rst_tx_go", tx_go, 0);
        check("rst_ack", ack, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant_id, 0);
        check("rst_count", tx_count, 0);
        check("rst_active", active, 0);

        // Single request on requester 2.
        ack_log.delete(); rx_log.delete();
        src_q[2].push_back(8'h5A);
        wait_idle(2000);
        check("single_ack_n", ack_log.size(), 1);
        check("single_ack_id", ack_at(0), 2);
        check("single_rx", rx_at(0), 8'h5A);
        check("single_count", tx_count, 1);

        // All four from reset.
        apply_reset();
        ack_log.delete(); rx_log.delete();
        for (int i = 0; i < NR; i++) src_q[i].push_back(8'h10 + 8'(i));
        wait_idle(4000);
        for (int i = 0; i < NR; i++) begin
            check("all4_ack_order", ack_at(i), i);
            check("all4_rx_order", rx_at(i), 32'h10 + i);
        end

        // Requesters 1 and 3 continuously requesting after 3 was served.
        ack_log.delete(); rx_log.delete();
        for (int k = 0; k < 4; k++) begin
            src_q[1].push_back(8'h20 + 8'(k));
            src_q[3].push_back(8'h30 + 8'(k));
        end
        wait_idle(6000);
        check("alt_ack_n", ack_log.size(), 8);
        for (int k = 0; k < 8; k++) check("alt_order", ack_at(k), (k % 2 == 1) ? 3 : 1);

        // Requester 0 withdraws and scribbles its data mid-transfer.
        apply_reset();
        ack_log.delete(); rx_log.delete();
        src_q[0].push_back(8'h33);
        n = 0;
        while (m_phase != 1 && n < 100) begin step(); n++; end
        check("drop_grant_seen", n < 100, 1);
        repeat (3) step();
        req[0] = 1'b0;
        req_data[7:0] = 8'hFF;
        src_q[0].delete();
        wait_idle(2000);
        check("drop_rx", rx_at(0), 8'h33);
        check("drop_ack_id", ack_at(0), 0);
        check("drop_ack_n", ack_log.size(), 1);

        // Reset in the middle of the data bits of a second byte.
        apply_reset();
        ack_log.delete(); rx_log.delete();
        tx_lat_max = 1;
        src_q[1].push_back(8'hA5);
        wait_idle(2000);
        src_q[1].push_back(8'hC3);
        n = 0;
        while (!(xs == 2 && x_bit == 4) && n < 500) begin step(); n++; end
        check("abort_reach_data", n < 500, 1);
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        step();
        check("abort_tx_go", tx_go, 0);
        check("abort_active", active, 0);
        check("abort_ack", ack, 0);
        check("abort_count", tx_count, 0);
        check("abort_line_idle", tx_line, 1);
        rst = 1'b0;
        repeat (20) step();
        check("abort_no_ack", ack_log.size(), 1);

        // Counter wrap with a 4-bit counter.
        apply_reset();
        for (int t = 1; t <= 17; t++) begin
            src_q[$urandom_range(NR - 1, 0)].push_back(8'($urandom));
            wait_idle(2000);
            if (t >= 15) check("count_wrap", tx_count, (t == 15) ? 15 : (t == 16) ? 0 : 1);
        end

        // Random traffic with random raise timing and transmitter latency.
        ack_log.delete(); rx_log.delete();
        tx_lat_max = 3;
        rand_raise = 1'b1;
        for (int k = 0; k < 40; k++) src_q[$urandom_range(NR - 1, 0)].push_back(8'($urandom));
        wait_idle(20000);
        check("rand_ack_n", ack_log.size(), 40);
        check("rand_rx_n", rx_log.size(), 40);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
